// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Master drives the request; slave returns status and result.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor diff = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to register signed overflow; otherwise ovf is 0.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] diff_q, diff_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             br_q, br_n;
    logic             bout_q, bout_n;
    logic             d, br_next, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_n;
`endif

    always_comb begin
        d       = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        last    = (cnt_q == CW'(WIDTH - 1));
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        diff_n  = diff_q;
        cnt_n   = cnt_q;
        br_n    = br_q;
        bout_n  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_n   = ovf_q;
`endif
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    state_n = SHIFT;
                    a_n     = bus.a;
                    b_n     = bus.b;
                    br_n    = bus.bin;
                    cnt_n   = '0;
                    diff_n  = '0;
                    bout_n  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_n   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                a_n    = {1'b0, a_q[WIDTH-1:1]};
                b_n    = {1'b0, b_q[WIDTH-1:1]};
                diff_n = {d, diff_q[WIDTH-1:1]};
                br_n   = br_next;
                cnt_n  = cnt_q + 1'b1;
                if (last) begin
                    state_n = DONE;
                    bout_n  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // borrow into MSB vs borrow out of MSB
                    ovf_n   = br_q ^ br_next;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            a_q    <= a_n;
            b_q    <= b_n;
            diff_q <= diff_n;
            cnt_q  <= cnt_n;
            br_q   <= br_n;
            bout_q <= bout_n;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= ovf_n;
`endif
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`else
    assign bus.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed, random, abort and
// back-to-back scenarios against an integer-arithmetic reference.
module tb_serial_sub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic         bin,
        output logic [W-1:0] d,
        output logic         bo,
        output logic         ov
    );
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r;
        d  = W'(ua - ub - int'(bin));
        bo = (ua < ub + int'(bin));
        r  = sa - sb - int'(bin);
`ifdef SERIAL_SUB_OVF_EN
        ov = (r < -(2 ** (W - 1))) || (r > 2 ** (W - 1) - 1);
`else
        ov = 1'b0;
`endif
    endfunction

    // Starts at a negedge in cycle 0; returns at the negedge of the done cycle.
    task automatic do_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         bin,
        input string        name
    );
        logic [W-1:0] ed;
        logic         eb, eo;
        model(a, b, bin, ed, eb, eo);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.bin   = 1'($urandom);
            end
            checks++;
            if (bus.busy !== (c <= W) || bus.done !== (c == W + 1)) begin
                errors++;
                $display("FAIL %s handshake cycle %0d: busy=%b done=%b",
                         name, c, bus.busy, bus.done);
            end
        end
        checks++;
        if (bus.diff !== ed || bus.bout !== eb || bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s result: got %h/%b/%b want %h/%b/%b",
                     name, bus.diff, bus.bout, bus.ovf, ed, eb, eo);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.bin   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 ||
            bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b ovf=%b",
                     bus.busy, bus.done, bus.diff, bus.bout, bus.ovf);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(8'h5A, 8'h3C, 1'b0, "v5a_3c");
        @(negedge clk);
        do_op(8'h00, 8'h01, 1'b0, "v00_01");
        do_op(8'h80, 8'h01, 1'b0, "v80_01");
        do_op(8'h10, 8'h10, 1'b1, "v10_10_bin");
        do_op(8'h7F, 8'hFF, 1'b0, "v7f_ff");
        do_op(8'hFF, 8'hFF, 1'b1, "vff_ff_bin");
    endtask

    task automatic test_hold();
        logic [W-1:0] d0;
        logic         b0, o0;
        d0 = bus.diff;
        b0 = bus.bout;
        o0 = bus.ovf;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.bin = 1'($urandom);
            checks++;
            if (bus.diff !== d0 || bus.bout !== b0 || bus.ovf !== o0 ||
                bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL hold %0d: got %h/%b/%b d=%b want %h/%b/%b",
                         i, bus.diff, bus.bout, bus.ovf, bus.done, d0, b0, o0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int seen_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        bus.bin   = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = (c == 3);
            if (c == 5) rst = 1'b1;
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL abort busy cycle %0d: busy=%b done=%b",
                         c, bus.busy, bus.done);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 ||
            bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort reset: busy=%b done=%b diff=%h bout=%b",
                     bus.busy, bus.done, bus.diff, bus.bout);
        end
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort no_done: activity cycles=%0d want 0",
                     seen_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ed;
        logic         eb, eo;
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.bin   = 1'b0;
        for (int c = 1; c <= 2 * (W + 1); c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== (c == W + 1 || c == 2 * (W + 1)) ||
                bus.busy !== !(c == W + 1 || c == 2 * (W + 1))) begin
                errors++;
                $display("FAIL b2b handshake cycle %0d: busy=%b done=%b",
                         c, bus.busy, bus.done);
            end
            if (c == W + 1) begin
                model(8'h05, 8'h03, 1'b0, ed, eb, eo);
                checks++;
                if (bus.diff !== ed || bus.bout !== eb || bus.ovf !== eo) begin
                    errors++;
                    $display("FAIL b2b first: got %h/%b/%b want %h/%b/%b",
                             bus.diff, bus.bout, bus.ovf, ed, eb, eo);
                end
                bus.a = 8'h03;
                bus.b = 8'h05;
            end
        end
        model(8'h03, 8'h05, 1'b0, ed, eb, eo);
        checks++;
        if (bus.diff !== ed || bus.bout !== eb || bus.ovf !== eo) begin
            errors++;
            $display("FAIL b2b second: got %h/%b/%b want %h/%b/%b",
                     bus.diff, bus.bout, bus.ovf, ed, eb, eo);
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
